// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: N_REQ packed operand pairs in, one registered sum out.
// ADDER_ARBITER_OVF_EN adds the registered signed-overflow flag.
interface adder_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_A;
    logic [N_REQ*DATA_W-1:0] req_B;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_S;
    logic                    rsp_ready;
`ifdef ADDER_ARBITER_OVF_EN
    logic                    ovf;
`endif

    modport master (
        output req_valid, req_A, req_B, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_S
`ifdef ADDER_ARBITER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req_valid, req_A, req_B, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_S
`ifdef ADDER_ARBITER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one DATA_W adder among N_REQ requesters; registered sum + winner id.
// ADDER_ARBITER_OVF_EN enables the registered signed-overflow output.
module adder_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    adder_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              found;
    logic              accept;
    int unsigned       cand;
    logic [DATA_W-1:0] a_sel, b_sel, sum;
    logic [DATA_W-1:0] rsp_S_q;
    logic [ID_W-1:0]   rsp_id_q;
`ifdef ADDER_ARBITER_OVF_EN
    logic              ovf_q;
`endif

    // First valid requester after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(rr_ptr) + off) % N_REQ;
            if (!found && bus.req_valid[ID_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    // Reset gates accept so req_ready stays low while i_rst is asserted.
    always_comb begin
        accept = found && ((state == IDLE) || bus.rsp_ready) && !i_rst;
    end

    always_comb begin
        a_sel = bus.req_A[int'(grant_idx)*DATA_W +: DATA_W];
        b_sel = bus.req_B[int'(grant_idx)*DATA_W +: DATA_W];
        sum   = a_sel + b_sel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = HOLD;
            HOLD:    if (!accept && bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_idx] = 1'b1;
        bus.rsp_valid = (state == HOLD);
        bus.rsp_S     = rsp_S_q;
        bus.rsp_id    = rsp_id_q;
`ifdef ADDER_ARBITER_OVF_EN
        bus.ovf       = ovf_q;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_S_q  <= '0;
            rsp_id_q <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
`ifdef ADDER_ARBITER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (accept) begin
            rsp_S_q  <= sum;
            rsp_id_q <= grant_idx;
            rr_ptr   <= grant_idx;
`ifdef ADDER_ARBITER_OVF_EN
            ovf_q    <= (a_sel[DATA_W-1] == b_sel[DATA_W-1]) && (sum[DATA_W-1] != a_sel[DATA_W-1]);
`endif
        end
    end
endmodule
